// File: rtl/channel_sample_timer.sv
// channel_sample_timer
//
// Per-channel sample-rate generator. Emits a one-cycle sample strobe every
// psc+1 system clocks while enabled, together with a wrapping waveform
// read address in 0..len.
//
// Optional build macro: CST_SHADOW_EN
//   defined   - prescaler/length shadows reload only on enable and at each
//               sample boundary, so mid-period writes are invisible.
//   undefined - shadows follow psc_i/len_i on every clock edge.
//
// Ports:
//   sys_clk_i      system clock, rising edge
//   sys_rst_i      asynchronous active-low reset
//   en_i           channel run enable (level)
//   psc_i          prescaler; sample period = psc_i + 1 clocks
//   len_i          last valid sample address (waveform length - 1)
//   sample_tick_o  one-cycle strobe: fetch sample at sample_addr_o
//   sample_addr_o  current waveform sample address
//   wrap_o         one-cycle strobe on the tick that returns address to 0
//   run_o          high while running
module channel_sample_timer #(
    parameter int unsigned PSC_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic                  en_i,
    input  logic [PSC_WIDTH-1:0]  psc_i,
    input  logic [ADDR_WIDTH-1:0] len_i,
    output logic                  sample_tick_o,
    output logic [ADDR_WIDTH-1:0] sample_addr_o,
    output logic                  wrap_o,
    output logic                  run_o
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e                state_q, state_d;
    logic [PSC_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PSC_WIDTH-1:0]  psc_sh_q, psc_sh_d;
    logic [ADDR_WIDTH-1:0] len_sh_q, len_sh_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  tick_q, tick_d;
    logic                  wrap_q, wrap_d;
    logic                  boundary;

    // >= rather than == so a shrinking prescaler can never strand the counter.
    assign boundary = (cnt_q >= psc_sh_q);

    // State register and registered outputs
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            psc_sh_q <= '0;
            len_sh_q <= '0;
            addr_q   <= '0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            psc_sh_q <= psc_sh_d;
            len_sh_q <= len_sh_d;
            addr_q   <= addr_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en_i)  state_d = StRun;
            StRun:   if (!en_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
`ifdef CST_SHADOW_EN
        psc_sh_d = psc_sh_q;
        len_sh_d = len_sh_q;
`else
        psc_sh_d = psc_i;
        len_sh_d = len_i;
`endif
        unique case (state_q)
            StIdle: begin
                if (en_i) begin
                    // Start tick presents sample 0 immediately.
                    cnt_d    = '0;
                    addr_d   = '0;
                    tick_d   = 1'b1;
                    psc_sh_d = psc_i;
                    len_sh_d = len_i;
                end
            end
            StRun: begin
                if (!en_i) begin
                    // Disable wins over a coincident boundary; address is held.
                    cnt_d = '0;
                end else if (boundary) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    if (addr_q >= len_sh_q) begin
                        addr_d = '0;
                        wrap_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
`ifdef CST_SHADOW_EN
                    psc_sh_d = psc_i;
                    len_sh_d = len_i;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign sample_tick_o = tick_q;
    assign sample_addr_o = addr_q;
    assign wrap_o        = wrap_q;
    assign run_o         = (state_q == StRun);

endmodule
